// File: rtl/divide16by8.sv
// Sequential unsigned 16/8 restoring divider, one quotient bit per clock.
// Latency 16 cycles after accept (0 for a zero divisor); start is ignored while busy.
module divide16by8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [3:0]  cnt;
  logic [7:0]  pr;
  logic [15:0] sh;
  logic [15:0] acc;
  logic [7:0]  dvs;

  logic        accept;
  logic        last_step;
  logic [8:0]  pr_shift;
  logic [8:0]  diff;
  logic        ge;
  logic [7:0]  pr_step;
  logic [15:0] acc_step;

  assign accept    = start && (state != RUN);
  assign last_step = (state == RUN) && (cnt == 4'd15);

  // The stored partial remainder is always below the divisor, so its 9th bit is
  // implicitly zero; the shifted value is at most 2*dvs-1 and the borrow of the
  // 9-bit difference is therefore an exact "less than" flag.
  always_comb begin
    pr_shift = {pr, sh[15]};
    diff     = pr_shift - {1'b0, dvs};
    ge       = ~diff[8];
    pr_step  = ge ? diff[7:0] : pr_shift[7:0];
    acc_step = {acc[14:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (divisor == 8'd0) ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (cnt == 4'd15) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 4'd0;
      pr          <= 8'd0;
      sh          <= 16'd0;
      acc         <= 16'd0;
      dvs         <= 8'd0;
      quotient    <= 16'd0;
      remainder   <= 8'd0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvs <= divisor;
      cnt <= 4'd0;
      pr  <= 8'd0;
      sh  <= dividend;
      acc <= 16'd0;
      if (divisor == 8'd0) begin
        quotient    <= 16'hFFFF;
        remainder   <= dividend[7:0];
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 4'd1;
      pr  <= pr_step;
      sh  <= {sh[14:0], 1'b0};
      acc <= acc_step;
      if (last_step) begin
        quotient    <= acc_step;
        remainder   <= pr_step;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
